// File: rtl/rr_mux16_1.sv
// Round-robin 16-to-1 collector: arbitrates among 16 producer channels and
// captures the winner's word into a single-entry valid/ready output register.
module rr_mux16_1 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           in_req,
  input  logic [16*WIDTH-1:0]   in_data,
  output logic [15:0]           in_ack,
  output logic [WIDTH-1:0]      out_data,
  output logic [3:0]            out_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_count
);

  localparam int unsigned NCH  = 16;
  localparam int unsigned SELW = 4;
  localparam int unsigned CNTW = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state;
  logic [SELW-1:0]   last;
  logic [SELW-1:0]   win;
  logic [SELW-1:0]   idx;
  logic              found;
  logic              load;
  logic [WIDTH-1:0]  win_data;

  assign out_valid = (state == FULL);

  // Search upward from last+1, wrapping; last itself is examined at the end.
  always_comb begin
    win   = last;
    idx   = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      idx = last + SELW'(i);
      if (!found && in_req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign load     = found & (~out_valid | out_ready) & ~reset;
  assign win_data = in_data[win*WIDTH +: WIDTH];

  always_comb begin
    in_ack = '0;
    if (load) in_ack[win] = 1'b1;
  end

  // Output register: a drain and a fresh load may share the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      out_data  <= '0;
      out_sel   <= '0;
      out_count <= '0;
      last      <= SELW'(NCH - 1);
    end else begin
      if (out_valid && out_ready) out_count <= out_count + CNTW'(1);
      if (load) begin
        state    <= FULL;
        out_data <= win_data;
        out_sel  <= win;
        last     <= win;
      end else if (out_ready) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux16_1.sv
// Bench for rr_mux16_1: scoreboard of captured words fed by a round-robin
// reference model, plus directed scenarios and randomized traffic.
module tb_rr_mux16_1;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [3:0]   sel;
    logic [W-1:0] data;
  } item_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [15:0]       in_req;
  logic [16*W-1:0]   in_data;
  logic [15:0]       in_ack;
  logic [W-1:0]      out_data;
  logic [3:0]        out_sel;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_count;

  item_t       exp_q[$];
  logic [15:0] exp_count;
  logic [15:0] m_grant_vec;
  int          m_last;
  int          n_tests = 0;
  int          n_fail  = 0;

  rr_mux16_1 #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_req    (in_req),
    .in_data   (in_data),
    .in_ack    (in_ack),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_req    = '0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reference model: grants by modular search from the last winner.
  initial begin
    logic [15:0] exp_ack;
    int          w;
    bit          hit;
    m_last      = 15;
    exp_count   = '0;
    m_grant_vec = '0;
    forever begin
      @(negedge clk);
      #2;
      exp_ack = '0;
      if (reset) begin
        exp_q.delete();
        exp_count = '0;
        m_last    = 15;
      end else if (in_req != 16'h0 && exp_q.size() == 0) begin
        w   = 0;
        hit = 1'b0;
        for (int d = 1; d <= 16; d++) begin
          if (!hit && in_req[(m_last + d) % 16]) begin
            w   = (m_last + d) % 16;
            hit = 1'b1;
          end
        end
        exp_ack[w] = 1'b1;
        exp_q.push_back('{sel: 4'(w), data: in_data[w*W +: W]});
        m_last = w;
      end
      check("in_ack", 32'(in_ack), 32'(exp_ack));
      m_grant_vec = exp_ack;
    end
  end

  // Monitor: compares the output register against the scoreboard head.
  initial begin
    item_t head;
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("out_count", 32'(out_count), 32'(exp_count));
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        check("out_data", 32'(out_data), 32'(head.data));
        check("out_sel", 32'(out_sel), 32'(head.sel));
        if (out_ready) begin
          void'(exp_q.pop_front());
          exp_count = exp_count + 16'd1;
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    in_req    = '0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset then idle.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_data", 32'(out_data), 32'h0);
      check("idle_sel", 32'(out_sel), 32'h0);
    end

    // All channels requesting: strict rotation 0..15 twice.
    for (int k = 0; k < 16; k++) in_data[k*W +: W] = 16'h1000 + 16'(k);
    in_req    = 16'hFFFF;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      check("rr_sel", 32'(out_sel), 32'(i % 16));
      check("rr_data", 32'(out_data), 32'h1000 + 32'(i % 16));
    end
    in_req = '0;
    tick();

    // Backpressure with channels 2 and 9.
    do_reset();
    in_data[2*W +: W] = 16'h2222;
    in_data[9*W +: W] = 16'h9999;
    in_req    = 16'h0204;
    out_ready = 1'b0;
    tick();
    check("bp_first_sel", 32'(out_sel), 32'd2);
    in_req = 16'h0200;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold_sel", 32'(out_sel), 32'd2);
      check("bp_hold_data", 32'(out_data), 32'h2222);
    end
    out_ready = 1'b1;
    tick();
    check("bp_swap_sel", 32'(out_sel), 32'd9);
    check("bp_count1", 32'(out_count), 32'd1);
    in_req = '0;
    tick();
    check("bp_count2", 32'(out_count), 32'd2);
    check("bp_empty", 32'(out_valid), 32'd0);

    // Sparse wrap: after ch14, ch0 wins ahead of 14.
    do_reset();
    out_ready = 1'b1;
    in_req    = 16'h4000;
    tick();
    check("wrap_sel14", 32'(out_sel), 32'd14);
    in_req = 16'h4001;
    tick();
    check("wrap_sel0", 32'(out_sel), 32'd0);
    in_req = 16'h4000;
    tick();
    check("wrap_sel14b", 32'(out_sel), 32'd14);
    in_req = '0;
    tick();

    // Reset while holding a stalled word discards it.
    out_ready         = 1'b0;
    in_data[3*W +: W] = 16'h3333;
    in_req            = 16'h0008;
    tick();
    in_req = '0;
    tick();
    reset = 1'b1;
    tick();
    check("rst_hold_valid", 32'(out_valid), 32'd0);
    check("rst_hold_count", 32'(out_count), 32'd0);
    reset = 1'b0;

    // Randomized traffic honoring the hold-until-ack protocol.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 16; k++) begin
        if (m_grant_vec[k]) begin
          in_req[k]          = 1'($urandom_range(0, 1));
          in_data[k*W +: W]  = 16'($urandom);
        end else if (!in_req[k] && $urandom_range(0, 3) == 0) begin
          in_req[k]          = 1'b1;
          in_data[k*W +: W]  = 16'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = (c == 1500);
      tick();
    end
    reset = 1'b0;

    // Single channel every cycle, long enough to wrap the delivery counter.
    do_reset();
    in_data[5*W +: W] = 16'hBEEF;
    in_req    = 16'h0020;
    out_ready = 1'b1;
    tick();
    check("single_sel", 32'(out_sel), 32'd5);
    check("single_data", 32'(out_data), 32'hBEEF);
    repeat (65536) tick();
    check("count_wrap", 32'(out_count), 32'h0);
    in_req = '0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_mux16_1.md
# rr_mux16_1

Round-robin 16-to-1 collector that gathers words from up to 16 producer channels onto one registered output stream. It also emits the 4-bit channel index of each word. It is the gathering counterpart of the 1-to-16 demultiplexer: its output stream (`out_data` plus `out_sel`) is shaped to drive that demultiplexer's data input and `selector` directly, so a sender/receiver pair can be built around a shared 16-bit bus. Arbitration is fair round-robin, and the output is a single-entry register with valid/ready flow control.

## Interface
- `WIDTH`, default 16: data word width per channel.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in_req`  input  16  per-channel request; bit k high = channel k presents a word.
- `in_data`  input  16*WIDTH  flattened channel words; channel k occupies `[k*WIDTH +: WIDTH]`.
- `in_ack`  output  16  one-hot pulse; bit k high for exactly the cycle channel k's word is captured.
- `out_data`  output  WIDTH  registered captured word.
- `out_sel`  output  4  index of the channel that produced `out_data`.
- `out_valid`  output  1  output register holds a word.
- `out_ready`  input  1  consumer accepts the word this cycle.
- `out_count`  output  16  number of words delivered to the consumer (`out_valid & out_ready`); wraps modulo 2^16.

## Operation
- Output register states:
  - EMPTY: `out_valid` = 0.
  - FULL: `out_valid` = 1.
- Load condition: `load = (|in_req) & (~out_valid | out_ready)`.
- When `load` is true:
  - Arbiter picks the winner w: the first requesting channel found searching upward from `last+1`, wrapping 15→0.
  - Register captures `out_data` ← channel w's word and `out_sel` ← w.
  - `out_valid` becomes 1 and `last` ← w.
  - `in_ack[w]` is 1 in the same cycle; this is a combinational function of current state and inputs.
- When `load` is false: `in_ack` = 0.
- FULL & `out_ready` & no requests → EMPTY.
- FULL & ~`out_ready` → hold. Data, sel and valid stay stable; no ack is issued.
- Simultaneous drain and load: the old word is delivered and the new word is captured in the same edge. Sustained throughput is therefore 1 word/cycle.
- A channel keeps `in_req` and its data stable until it sees `in_ack`. Words are captured only on ack, never duplicated or dropped.
- `out_count` increments on every `out_valid & out_ready` edge and wraps 0xFFFF → 0x0000.
- A single requester is served every cycle it requests, with no bubbles.
- Reset mid-operation: a held word is discarded, not delivered. `out_count` is not incremented for it.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_sel` = 0, `out_count` = 0.
  - `last` = 15, so channel 0 has first priority.
  - `in_ack` = 0 while `reset` is high, regardless of requests.
- Latency: a request sampled at edge N with the register free gives `in_ack` during cycle N−1→N. `out_valid` and data are visible after edge N. Request-to-output latency is 1 cycle.
- The `out_ready` → `in_ack` combinational path is permitted. `in_req` → `in_ack` is combinational through the arbiter.
- Fairness: with all 16 channels requesting continuously and `out_ready` = 1, each channel is granted exactly once in every 16 consecutive grants.

## Test plan
- Reset then idle: hold `reset` for 2 cycles, `in_req` = 0 → `out_valid` = 0, `out_data` = 0, `out_sel` = 0, `out_count` = 0, `in_ack` = 0 for 10 cycles.
- Single channel:
  - Stimulus: `in_req` = 0x0020, channel 5 data = 0xBEEF, `out_ready` = 1.
  - Response: `in_ack` = 0x0020 each cycle; `out_data` = 0xBEEF and `out_sel` = 5 starting one cycle later; `out_count` increments every cycle.
- Round-robin:
  - Stimulus: `in_req` = 0xFFFF, channel k data = 0x1000+k, `out_ready` = 1, for 32 cycles after reset.
  - Response: `out_sel` sequence is 0,1,…,15,0,…,15; `out_data` = 0x1000+`out_sel`.
- Backpressure:
  - Stimulus: channels 2 and 9 request; `out_ready` = 0 for 5 cycles, then 1.
  - Response: first word is ch 2, held stable with `in_ack` = 0 while stalled. Then ch 9 loads on the same edge ch 2 drains. `out_count` = 1 after that edge and 2 after the next edge.
- Sparse wrap:
  - Stimulus: `last` = 14 (ch 14 served), then `in_req` = 0x4001.
  - Response: channel 0 wins ahead of 14; the next grant is 14.
- Reset mid-hold and counter wrap:
  - Stimulus 1: assert `reset` while FULL and stalled → next cycle `out_valid` = 0, `out_count` = 0.
  - Stimulus 2: deliver 65,536 words → `out_count` returns to 0x0000.
